button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Parametrised, multi-channel front end for the game's push-buttons: a, b, up, down, left, right and start.
- Per channel it provides a synchroniser, a counter-based debouncer and a press/release edge detector.
- Optional per channel: hold-to-repeat pulses for cursor movement.
- Sits between the raw button pins and the top-level game FSM, so the FSM consumes only clean single-cycle events.

Parameters:
- NUM_BUTTONS, 7: number of independent channels (N).
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to accept a level change. Must be >= 1.
- REPEAT_DELAY, 20: cycles from accepted press to first repeat pulse. Must be >= 2.
- REPEAT_RATE, 5: cycles between subsequent repeat pulses. Must be >= 1.
- REPEAT_MASK, 7'b0111100: bit i = 1 enables auto-repeat on channel i (default: up/down/left/right).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. reset=0 clears all state immediately.
- btn_in  in  N  raw asynchronous button levels, 1 = pressed.
- btn_level  out  N  debounced level per channel.
- btn_press  out  N  one-cycle pulse on each accepted 0->1 transition.
- btn_release  out  N  one-cycle pulse on each accepted 1->0 transition.
- btn_repeat  out  N  one-cycle hold-repeat pulse.
- btn_event  out  N  btn_press | btn_repeat, registered. This is the FSM's "act" strobe.
- any_pressed  out  1  OR of btn_level.

Behaviour:
- Reset:
  - All registers and outputs are 0: sync flops, stable levels, debounce counters, repeat counters and all pulses.
  - Reset asserted mid-debounce or mid-hold discards progress. No pulse is emitted during or on exit from reset.
  - A button held through reset release must still debounce from 0; it produces btn_press after the normal latency.
- Synchroniser:
  - Two flops per channel. sync = second flop.
- Debounce, per channel:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If sync == level: counter clears.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, level toggles and the counter clears.
  - A glitch lasting fewer than DEBOUNCE_CYCLES cycles leaves level unchanged.
- Latency:
  - Input held from sampling edge k gives level = 1 after edge k+1+DEBOUNCE_CYCLES. This is DEBOUNCE_CYCLES+2 edges; 6 with defaults.
  - btn_press is high for exactly the first cycle in which level reads 1.
  - btn_release is high for exactly the first cycle in which level reads 0.
- Edge detection:
  - Compares level with its previous-cycle value.
  - press and release can never both be high on the same channel.
- Auto-repeat, with the feature compiled in and REPEAT_MASK[i] = 1:
  - The repeat counter loads on press and counts while level = 1.
  - The first btn_repeat fires REPEAT_DELAY cycles after the btn_press cycle.
  - Further pulses follow every REPEAT_RATE cycles while held.
  - Release clears the counter the same cycle level drops. No repeat pulse occurs in or after the btn_release cycle.
  - A repeat pulse never coincides with btn_press.
- btn_event:
  - Registered one cycle after press/repeat, matching the FSM's registered-input timing.
  - Latency from btn_press to btn_event is 1 cycle.
- Channel independence:
  - Simultaneous presses on several channels produce simultaneous pulses on each. There is no priority or arbitration.
  - Conflict resolution (e.g. up+down) belongs to the consumer.
- Per-channel state: 2 sync flops, 1 level, 1 previous-level, debounce counter, repeat counter (width clog2(max(REPEAT_DELAY, REPEAT_RATE)+1)).

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined: repeat counters are instantiated and behave as above for channels set in REPEAT_MASK. Masked-off channels have btn_repeat = 0.
- Undefined: no repeat counters are synthesised, btn_repeat is tied to 0 and btn_event = registered btn_press only. REPEAT_DELAY, REPEAT_RATE and REPEAT_MASK are accepted but ignored.

Test Plan (defaults: N=7, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5):
- Reset: hold reset=0 with btn_in=7'h7F, then release.
  - All outputs are 0 during reset.
  - btn_press = 7'h7F exactly once, 6 cycles after release; btn_level = 7'h7F thereafter.
- Bounce: on channel 0 (a), toggle 1,0,1,0 on consecutive cycles, then hold 1 for 10 cycles.
  - Exactly one btn_press[0] pulse, asserted 6 cycles after the final rising sample.
  - A 3-cycle glitch alone produces no pulse.
- Release: on start (bit 6), hold for 15 cycles then drop to 0.
  - One btn_press[6] and one btn_release[6], the release 6 cycles after the drop.
  - btn_repeat[6] stays 0 (masked).
- Auto-repeat with BUTTON_AUTO_REPEAT_EN defined: hold up (bit 2) for 40 cycles after btn_press.
  - btn_repeat[2] pulses at +20, +25, +30, +35 and +40.
  - btn_event[2] shows 6 pulses, each 1 cycle after its source pulse.
  - Release gives no further pulses.
- Macro undefined, same stimulus: btn_repeat = 0 throughout; btn_event[2] pulses once.
- Simultaneous: assert down and right on the same edge while a reset pulse hits mid-debounce.
  - Counters clear and no pulses occur.
  - After re-hold, both btn_press bits assert in the same cycle.

Source files
------------

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: two-flop synchroniser, counter debouncer and press/release edge detect.
// Define BUTTON_AUTO_REPEAT_EN to add hold-to-repeat pulses on the channels selected by REPEAT_MASK.
module button_conditioner #(
    parameter int                     NUM_BUTTONS     = 7,
    parameter int                     DEBOUNCE_CYCLES = 4,
    parameter int                     REPEAT_DELAY    = 20,
    parameter int                     REPEAT_RATE     = 5,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = 7'b0111100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] btn_in,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic [NUM_BUTTONS-1:0] btn_repeat,
    output logic [NUM_BUTTONS-1:0] btn_event,
    output logic                   any_pressed
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 2) begin : g_bad_delay
        $error("REPEAT_DELAY must be >= 2");
    end
    if (REPEAT_RATE < 1) begin : g_bad_rate
        $error("REPEAT_RATE must be >= 1");
    end
    if ($bits(REPEAT_MASK) != NUM_BUTTONS) begin : g_bad_mask
        $error("REPEAT_MASK width must equal NUM_BUTTONS");
    end

    logic [NUM_BUTTONS-1:0] sync_a;
    logic [NUM_BUTTONS-1:0] sync_b;
    logic [NUM_BUTTONS-1:0] level;
    logic [NUM_BUTTONS-1:0] prev_level;
    logic [DB_W-1:0]        db_cnt [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] press_pulse;
    logic [NUM_BUTTONS-1:0] release_pulse;
    logic [NUM_BUTTONS-1:0] repeat_pulse;
    logic [NUM_BUTTONS-1:0] event_q;

    // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples; any agreement restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a     <= '0;
            sync_b     <= '0;
            level      <= '0;
            prev_level <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a     <= btn_in;
            sync_b     <= sync_a;
            prev_level <= level;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (sync_b[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= ~level[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press_pulse   = level & ~prev_level;
    assign release_pulse = ~level & prev_level;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LOAD = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LOAD  = RPT_W'(REPEAT_RATE - 1);

    logic [RPT_W-1:0] rpt_cnt [NUM_BUTTONS];

    // Counter reaching zero while held marks a repeat; it then reloads with the shorter rate interval.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                rpt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (!REPEAT_MASK[i] || !level[i]) begin
                    rpt_cnt[i] <= '0;
                end else if (press_pulse[i]) begin
                    rpt_cnt[i] <= DELAY_LOAD;
                end else if (rpt_cnt[i] == '0) begin
                    rpt_cnt[i] <= RATE_LOAD;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        repeat_pulse = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            repeat_pulse[i] = REPEAT_MASK[i] & level[i] & ~press_pulse[i] & (rpt_cnt[i] == '0);
        end
    end
`else
    assign repeat_pulse = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            event_q <= '0;
        end else begin
            event_q <= press_pulse | repeat_pulse;
        end
    end

    assign btn_level   = level;
    assign btn_press   = press_pulse;
    assign btn_release = release_pulse;
    assign btn_repeat  = repeat_pulse;
    assign btn_event   = event_q;
    assign any_pressed = |level;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: reset, bounce, glitch, release, auto-repeat and simultaneous presses.
// Repeat expectations follow BUTTON_AUTO_REPEAT_EN so the same bench covers both builds.
module tb_button_conditioner;

    localparam int N = 7;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit RPT_ON = 1'b1;
`else
    localparam bit RPT_ON = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_repeat;
    logic [N-1:0] btn_event;
    logic         any_pressed;

    int vectors;
    int miscompares;
    int press_cnt   [N];
    int release_cnt [N];
    int repeat_cnt  [N];
    int event_cnt   [N];
    int both_cnt;

    button_conditioner dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat),
        .btn_event   (btn_event),
        .any_pressed (any_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [N-1:0] value);
        btn_in = value;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearCounts();
        for (int i = 0; i < N; i++) begin
            press_cnt[i]   = 0;
            release_cnt[i] = 0;
            repeat_cnt[i]  = 0;
            event_cnt[i]   = 0;
        end
        both_cnt = 0;
    endtask

    // Advance one clock and sample #1 after the edge, tallying every pulse seen.
    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                press_cnt[i]   += int'(btn_press[i]);
                release_cnt[i] += int'(btn_release[i]);
                repeat_cnt[i]  += int'(btn_repeat[i]);
                event_cnt[i]   += int'(btn_event[i]);
                if (btn_press[i] && btn_release[i]) both_cnt++;
            end
        end
    endtask

    initial begin
        logic exp_rep;
        logic prev_src;
        logic exp_evt;
        int   rep_total;
        vectors     = 0;
        miscompares = 0;
        clearCounts();
        reset = 1'b0;
        applyStimulus(7'h7F);

        // Reset held with every button pressed.
        tick(3);
        checkOutput("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_repeat, btn_event, any_pressed}), 32'd0);
        clearCounts();
        reset = 1'b1;
        tick(5);
        checkOutput("reset_exit_no_press", 32'(btn_press), 32'h00);
        checkOutput("reset_exit_level0", 32'(btn_level), 32'h00);
        tick(1);
        checkOutput("reset_press", 32'(btn_press), 32'h7F);
        checkOutput("reset_level", 32'(btn_level), 32'h7F);
        checkOutput("reset_any", 32'(any_pressed), 32'd1);
        tick(1);
        checkOutput("reset_press_once", 32'(btn_press), 32'h00);
        checkOutput("reset_event", 32'(btn_event), 32'h7F);
        tick(1);
        checkOutput("reset_event_once", 32'(btn_event), 32'h00);
        checkOutput("reset_level_hold", 32'(btn_level), 32'h7F);
        applyStimulus(7'h00);
        tick(6);
        checkOutput("all_release", 32'(btn_release), 32'h7F);
        checkOutput("all_level0", 32'(btn_level), 32'h00);
        tick(4);
        checkOutput("reset_press_count_a", 32'(press_cnt[0]), 32'd1);
        checkOutput("reset_repeat_none", 32'(repeat_cnt[2] + repeat_cnt[5]), 32'd0);

        // Bounce on channel a: 1,0,1,0 then a steady hold.
        clearCounts();
        applyStimulus(7'h01); tick(1);
        applyStimulus(7'h00); tick(1);
        applyStimulus(7'h01); tick(1);
        applyStimulus(7'h00); tick(1);
        applyStimulus(7'h01);
        tick(5);
        checkOutput("bounce_no_early_press", 32'(press_cnt[0]), 32'd0);
        tick(1);
        checkOutput("bounce_press", 32'(btn_press), 32'h01);
        tick(4);
        checkOutput("bounce_press_count", 32'(press_cnt[0]), 32'd1);
        applyStimulus(7'h00);
        tick(10);
        checkOutput("bounce_release_count", 32'(release_cnt[0]), 32'd1);

        // A 3-cycle glitch must not be accepted.
        clearCounts();
        applyStimulus(7'h01); tick(3);
        applyStimulus(7'h00); tick(10);
        checkOutput("glitch_press_count", 32'(press_cnt[0]), 32'd0);
        checkOutput("glitch_level", 32'(btn_level), 32'h00);

        // Start held 15 cycles then dropped.
        clearCounts();
        applyStimulus(7'h40);
        tick(15);
        applyStimulus(7'h00);
        tick(5);
        checkOutput("start_no_early_release", 32'(release_cnt[6]), 32'd0);
        tick(1);
        checkOutput("start_release", 32'(btn_release), 32'h40);
        checkOutput("start_level0", 32'(btn_level[6]), 32'd0);
        tick(5);
        checkOutput("start_press_count", 32'(press_cnt[6]), 32'd1);
        checkOutput("start_release_count", 32'(release_cnt[6]), 32'd1);
        checkOutput("start_repeat_masked", 32'(repeat_cnt[6]), 32'd0);
        checkOutput("start_no_overlap", 32'(both_cnt), 32'd0);

        // Up held: first repeat 20 cycles after press, then every 5 while the debounced level stays high.
        clearCounts();
        applyStimulus(7'h04);
        tick(6);
        checkOutput("up_press", 32'(btn_press), 32'h04);
        prev_src  = 1'b1;
        rep_total = 0;
        for (int d = 1; d <= 52; d++) begin
            if (d == 36) applyStimulus(7'h00);
            tick(1);
            exp_rep = RPT_ON && d >= 20 && d <= 40 && ((d - 20) % 5 == 0);
            exp_evt = prev_src;
            checkOutput($sformatf("up_cycle_%0d", d),
                        32'({btn_level[2], btn_release[2], btn_repeat[2], btn_event[2]}),
                        32'({(d <= 40), (d == 41), exp_rep, exp_evt}));
            prev_src = exp_rep;
            if (exp_rep) rep_total++;
        end
        checkOutput("up_repeat_count", 32'(repeat_cnt[2]), 32'(rep_total));
        checkOutput("up_event_count", 32'(event_cnt[2]), 32'(rep_total + 1));
        checkOutput("up_press_count", 32'(press_cnt[2]), 32'd1);

        // Down and right together, interrupted by reset mid-debounce.
        clearCounts();
        applyStimulus(7'h28);
        tick(3);
        reset = 1'b0;
        tick(2);
        checkOutput("simul_in_reset", 32'({btn_level, btn_press, btn_event}), 32'd0);
        reset = 1'b1;
        tick(5);
        checkOutput("simul_restart_no_press", 32'(press_cnt[3] + press_cnt[5]), 32'd0);
        tick(1);
        checkOutput("simul_press", 32'(btn_press), 32'h28);
        tick(2);
        // Asynchronous clear taken mid-cycle while held.
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_clear", 32'({btn_level, any_pressed}), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(6);
        checkOutput("simul_repress", 32'(btn_press), 32'h28);
        applyStimulus(7'h00);
        tick(10);
        checkOutput("simul_press_total", 32'(press_cnt[3] + press_cnt[5]), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
